inv_rho_pi_serial: RTL and testbench
====================================

INV_RHO_PI_SERIAL -- requirements
Module: inv_rho_pi_serial

Interface
REQ-001 The block SHALL have no parameters; the lane width is fixed at 64 bits and the state width at 1600 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_state  input  1600  rho-pi-permuted state; slot s occupies bits [1599-64s : 1536-64s].
REQ-005 in_valid  input  1  in_state is valid this cycle.
REQ-006 in_ready  output  1  block can accept a state this cycle.
REQ-007 out_lane  output  64  recovered pre-rho-pi lane.
REQ-008 out_idx  output  5  index k (0..24) of out_lane.
REQ-009 out_last  output  1  high with lane 24.
REQ-010 out_valid  output  1  out_lane, out_idx and out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the lane.

Function
REQ-012 The block SHALL invert rho-pi, emitting lanes 0..24 serially in ascending k order, one lane per accepted out handshake.
REQ-013 Slot holding lane k, listed for k=0..24: 0,10,20,5,15,16,1,11,21,6,7,17,2,12,22,23,8,18,3,13,14,24,9,19,4.
REQ-014 Forward right-rotate r_k, listed for k=0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
REQ-015 out_lane SHALL equal the captured slot(k) rotated left by r_k, which undoes the forward right-rotate.
REQ-016 The FSM SHALL have two states, IDLE and EMIT.
REQ-017 In IDLE: in_ready=1 and out_valid=0.
REQ-018 In EMIT: in_ready=0 and out_valid=1.
REQ-019 IDLE with in_valid=1 SHALL capture in_state into a 1600-bit holding register, set idx=0 and move to EMIT on the next cycle.
REQ-020 Input-to-first-lane latency SHALL be 1 cycle.
REQ-021 In EMIT, out_lane, out_idx and out_last SHALL be combinational from the holding register and idx.
REQ-022 In EMIT, outputs SHALL hold stable while out_ready=0.
REQ-023 An out handshake at idx<24 SHALL increment idx.
REQ-024 An out handshake at idx=24 SHALL return the FSM to IDLE; the next state is accepted one cycle later (26 cycles per state with out_ready tied high).
REQ-025 in_valid while in EMIT SHALL be ignored, not captured, and SHALL NOT disturb emission.
REQ-026 idx SHALL never exceed 24; values 25..31 are unreachable.
REQ-027 out_lane SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst SHALL force IDLE, idx=0 and the holding register to 0, giving outputs in_ready=1, out_valid=0, out_last=0, out_idx=0 and out_lane=0.
REQ-029 rst asserted mid-EMIT SHALL abandon the state in progress; no further lanes of it are emitted.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-031 The slot table (REQ-013) and rotation table (REQ-014) SHALL live in a shared Keccak package as constants, alongside lane-width and lane-count constants.
REQ-032 A combinational sub-module rotl64 (64-bit data, 6-bit amount, rotate left) SHALL perform the inverse rotation.

Verification
REQ-033 in_state = 64'h8000_0000_0000_0000 in bits [959:896], all else 0 -> lane 1 = 64'h1; all other lanes 0; out_last only with idx 24.
REQ-034 Round trip: random 25 lanes through the forward rho-pi model -> DUT returns the original lanes, k=0..24, over 1000 random states.
REQ-035 out_ready toggled randomly -> outputs stable during stalls, no lane dropped or duplicated, exactly 25 handshakes per state.
REQ-036 Two back-to-back states with in_valid held high, out_ready=1 -> second state accepted on the cycle after lane 24 of the first; total 52 cycles.
REQ-037 rst pulsed at idx=12 -> next cycle out_valid=0 and in_ready=1; a fresh state then emits from idx 0 correctly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants: lane geometry plus the rho-pi slot and rotation tables.
// Also holds the FSM state type for the serial inverse rho-pi block.
package keccak_pkg;

    localparam int unsigned LaneW    = 64;
    localparam int unsigned NumLanes = 25;
    localparam int unsigned StateW   = LaneW * NumLanes;
    localparam int unsigned IdxW     = 5;
    localparam int unsigned RotW     = 6;

    localparam logic [IdxW-1:0] LastIdx = 5'd24;

    // Slot (in the permuted state) that holds lane k after rho-pi.
    localparam logic [IdxW-1:0] SlotOf [NumLanes] = '{
        5'd0,  5'd10, 5'd20, 5'd5,  5'd15,
        5'd16, 5'd1,  5'd11, 5'd21, 5'd6,
        5'd7,  5'd17, 5'd2,  5'd12, 5'd22,
        5'd23, 5'd8,  5'd18, 5'd3,  5'd13,
        5'd14, 5'd24, 5'd9,  5'd19, 5'd4
    };

    // Forward right-rotate applied to lane k; undone here by a left-rotate.
    localparam logic [RotW-1:0] RotOf [NumLanes] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic {
        StIdle,
        StEmit
    } state_e;

endpackage

// File: rtl/rotl64.sv
// Combinational 64-bit rotate-left by a 6-bit amount.
module rotl64 (
    input  logic [63:0] data_i,
    input  logic [5:0]  amt_i,
    output logic [63:0] data_o
);

    logic [127:0] dbl;

    // Upper half of the doubled word shifted left is the rotated word.
    always_comb begin
        dbl    = {data_i, data_i} << amt_i;
        data_o = dbl[127:64];
    end

endmodule

// File: rtl/inv_rho_pi_serial.sv
// Serial inverse rho-pi: captures one permuted 1600-bit state and emits the
// 25 recovered lanes in ascending index order, one per output handshake.
module inv_rho_pi_serial
    import keccak_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1599:0] in_state,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [63:0]   out_lane,
    output logic [4:0]    out_idx,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    state_e                              state_q, state_d;
    logic   [StateW-1:0]                 hold_q, hold_d;
    logic   [IdxW-1:0]                   idx_q, idx_d;
    logic   [NumLanes-1:0][LaneW-1:0]    hold_lanes;
    logic   [IdxW-1:0]                   slot;
    logic   [IdxW-1:0]                   pos;
    logic   [LaneW-1:0]                  sel_lane;
    logic   [LaneW-1:0]                  rot_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    hold_d  = in_state;
                    idx_d   = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Slot s sits at the top of the state, so packed lane index is 24 - s.
    always_comb begin
        hold_lanes = hold_q;
        slot       = SlotOf[idx_q];
        pos        = LastIdx - slot;
        sel_lane   = hold_lanes[pos];
    end

    rotl64 u_rotl64 (
        .data_i (sel_lane),
        .amt_i  (RotOf[idx_q]),
        .data_o (rot_lane)
    );

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StEmit);
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == LastIdx);
        out_lane  = out_valid ? rot_lane : '0;
    end

endmodule

// File: tb/tb_inv_rho_pi_serial.sv
// Directed bench for inv_rho_pi_serial: builds permuted states with an
// independent forward rho-pi model and checks every emitted lane.
module tb_inv_rho_pi_serial;

    logic          clk = 1'b0;
    logic          rst;
    logic [1599:0] in_state;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   out_lane;
    logic [4:0]    out_idx;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    int slot_tbl [25] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                          23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
    int rot_tbl  [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                          41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic [63:0]   exp_a [25];
    logic [63:0]   exp_b [25];
    logic [1599:0] st_a, st_b;

    inv_rho_pi_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_state  (in_state),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_lane  (out_lane),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    // Forward rho-pi: lane k is right-rotated and placed in its slot.
    function automatic logic [1599:0] fwd(input logic [63:0] l [25]);
        logic [1599:0] st;
        st = '0;
        for (int k = 0; k < 25; k++)
            st[1599 - 64*slot_tbl[k] -: 64] = rotr(l[k], rot_tbl[k]);
        return st;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  64'(in_ready),  64'd1);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_last"},  64'(out_last),  64'd0);
        check({tag, " out_idx"},   64'(out_idx),   64'd0);
        check({tag, " out_lane"},  out_lane,       64'd0);
    endtask

    task automatic check_lane(input string tag, input int k, input logic [63:0] exp);
        string t;
        t = $sformatf("%s k=%0d", tag, k);
        check({t, " out_valid"}, 64'(out_valid), 64'd1);
        check({t, " in_ready"},  64'(in_ready),  64'd0);
        check({t, " out_idx"},   64'(out_idx),   64'(k));
        check({t, " out_last"},  64'(out_last),  64'(k == 24));
        check({t, " out_lane"},  out_lane,       exp);
    endtask

    // Present a state in IDLE; the first lane appears one cycle later.
    task automatic send(input logic [1599:0] st);
        in_state = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            check_lane(tag, k, exp_a[k]);
            tick();
        end
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < 25; k++) exp_a[k] = {$urandom, $urandom};
        st_a = fwd(exp_a);
    endtask

    initial begin
        int hs;
        int cyc;

        rst       = 1'b1;
        in_state  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // Single bit in slot 10 recovers as lane 1 = 1.
        for (int k = 0; k < 25; k++) exp_a[k] = (k == 1) ? 64'h1 : 64'h0;
        st_a = '0;
        st_a[959:896] = 64'h8000_0000_0000_0000;
        send(st_a);
        drain_a("onebit");
        check_idle("onebit end");

        // Round trip over random states.
        for (int n = 0; n < 1000; n++) begin
            rand_lanes();
            send(st_a);
            drain_a($sformatf("rt%0d", n));
        end
        check_idle("rt end");

        // Random output stalls; each sample must match the lane not yet taken.
        for (int n = 0; n < 4; n++) begin
            rand_lanes();
            send(st_a);
            hs  = 0;
            cyc = 0;
            while (hs < 25 && cyc < 2000) begin
                out_ready = 1'($urandom_range(0, 1));
                check_lane($sformatf("stall%0d", n), hs, exp_a[hs]);
                if (out_ready) hs++;
                tick();
                cyc++;
            end
            check($sformatf("stall%0d handshakes", n), 64'(hs), 64'd25);
            out_ready = 1'b1;
            check_idle($sformatf("stall%0d end", n));
        end

        // Back-to-back with in_valid held; B sits on the bus during A's emission.
        rand_lanes();
        for (int k = 0; k < 25; k++) exp_b[k] = {$urandom, $urandom};
        st_b      = fwd(exp_b);
        out_ready = 1'b1;
        in_state  = st_a;
        in_valid  = 1'b1;
        cyc       = 0;
        tick();
        cyc++;
        in_state = st_b;
        for (int k = 0; k < 25; k++) begin
            check_lane("b2b A", k, exp_a[k]);
            tick();
            cyc++;
        end
        check("b2b gap in_ready",  64'(in_ready),  64'd1);
        check("b2b gap out_valid", 64'(out_valid), 64'd0);
        tick();
        cyc++;
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            check_lane("b2b B", k, exp_b[k]);
            tick();
            cyc++;
        end
        check("b2b cycles", 64'(cyc), 64'd52);
        check_idle("b2b end");

        // Reset at idx 12 with a simultaneous handshake abandons the state.
        rand_lanes();
        send(st_a);
        for (int k = 0; k < 12; k++) begin
            check_lane("rstmid", k, exp_a[k]);
            tick();
        end
        check("rstmid idx before", 64'(out_idx), 64'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rstmid after");
        tick();
        tick();
        check_idle("rstmid quiet");
        rand_lanes();
        send(st_a);
        drain_a("rstmid fresh");
        check_idle("rstmid fresh end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
